// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out for the NES framebuffer: 2x2 upscale centred with side borders.
// Optional SCANLINE_EN macro halves colour intensity on odd VGA lines inside the picture.
module vga_scanout #(
    parameter int           H_ACTIVE   = 640,
    parameter int           H_FP       = 16,
    parameter int           H_SYNC     = 96,
    parameter int           H_BP       = 48,
    parameter int           V_ACTIVE   = 480,
    parameter int           V_FP       = 10,
    parameter int           V_SYNC     = 2,
    parameter int           V_BP       = 33,
    parameter int           X_OFFSET   = 64,
    parameter int           FB_LAT     = 1,
    parameter logic [8:0]   BORDER_RGB = 9'o000
) (
    input  logic       vga_clk,
    input  logic       vga_rst,
    input  logic [8:0] rgb,
    output logic [7:0] pix_ptr_x,
    output logic [7:0] pix_ptr_y,
    output logic       fb_cs,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [2:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic       vblank,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] PIC_LO   = 10'(X_OFFSET);
    localparam logic [9:0] PIC_HI   = 10'(X_OFFSET + 512);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    // Flag bits carried alongside the framebuffer read: [0]=hs_n [1]=vs_n [2]=de [3]=sel [4]=dim
`ifdef SCANLINE_EN
    localparam int FW = 5;
`else
    localparam int FW = 4;
`endif
    localparam logic [FW-1:0] FLAGS_RST = FW'(3);

    logic [9:0]    hCnt_q, hCnt_d;
    logic [9:0]    vCnt_q, vCnt_d;
    logic          inPic;
    logic          visible;
    logic [FW-1:0] flags0;
    logic [FW-1:0] flagsAl;
    logic [8:0]    colour_d, colour_q;
    logic          hs_q, vs_q, de_q;
    logic          vblank_q, frameTick_q;

    always_comb begin
        hCnt_d = hCnt_q + 10'd1;
        vCnt_d = vCnt_q;
        if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign inPic   = (hCnt_q >= PIC_LO) && (hCnt_q < PIC_HI) && (vCnt_q < V_VIS);
    assign visible = (hCnt_q < 10'(H_ACTIVE)) && (vCnt_q < V_VIS);

    assign pix_ptr_x = inPic ? 8'((hCnt_q - PIC_LO) >> 1) : 8'd0;
    assign pix_ptr_y = inPic ? 8'(vCnt_q >> 1) : 8'd0;
    assign fb_cs     = inPic;

    always_comb begin
        flags0    = '0;
        flags0[0] = !((hCnt_q >= HS_START) && (hCnt_q < HS_END));
        flags0[1] = !((vCnt_q >= VS_START) && (vCnt_q < VS_END));
        flags0[2] = visible;
        flags0[3] = inPic;
`ifdef SCANLINE_EN
        flags0[4] = inPic && vCnt_q[0];
`endif
    end

    // Delay the stage-0 flags by the framebuffer latency so they line up with rgb
    generate
        if (FB_LAT == 0) begin : g_noDelay
            assign flagsAl = flags0;
        end else begin : g_delay
            logic [FW-1:0] pipe_q [FB_LAT];
            always_ff @(posedge vga_clk) begin
                if (vga_rst) begin
                    for (int i = 0; i < FB_LAT; i++) pipe_q[i] <= FLAGS_RST;
                end else begin
                    pipe_q[0] <= flags0;
                    for (int i = 1; i < FB_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign flagsAl = pipe_q[FB_LAT-1];
        end
    endgenerate

    always_comb begin
        colour_d = '0;
        if (flagsAl[3]) begin
            colour_d = rgb;
        end else if (flagsAl[2]) begin
            colour_d = BORDER_RGB;
        end
`ifdef SCANLINE_EN
        if (flagsAl[3] && flagsAl[4]) begin
            colour_d = {1'b0, rgb[8:7], 1'b0, rgb[5:4], 1'b0, rgb[2:1]};
        end
`endif
    end

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            colour_q    <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            vblank_q    <= 1'b0;
            frameTick_q <= 1'b0;
        end else begin
            colour_q    <= colour_d;
            hs_q        <= flagsAl[0];
            vs_q        <= flagsAl[1];
            de_q        <= flagsAl[2];
            vblank_q    <= (vCnt_q >= V_VIS);
            frameTick_q <= (hCnt_q == 10'd0) && (vCnt_q == V_VIS);
        end
    end

    assign vga_r      = colour_q[8:6];
    assign vga_g      = colour_q[5:3];
    assign vga_b      = colour_q[2:0];
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign vga_de     = de_q;
    assign vblank     = vblank_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with FB_LAT=1, border 9'o700 and a short 34-line frame.
module tb_vga_scanout;

    localparam int V_ACT   = 24;
    localparam int V_LASTL = 33;

    logic       vga_clk = 1'b0;
    logic       vga_rst;
    logic [8:0] rgb = 9'd0;
    logic [7:0] pix_ptr_x, pix_ptr_y;
    logic       fb_cs;
    logic [2:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de;
    logic       vblank, frame_tick;

    int  checks = 0;
    int  errors = 0;
    int  hModel = 0;
    int  vModel = 0;
    int  edgeCount = 0;
    int  runLen;
    logic forceWhite = 1'b0;

    vga_scanout #(
        .V_ACTIVE   (V_ACT),
        .V_FP       (4),
        .V_SYNC     (2),
        .V_BP       (4),
        .FB_LAT     (1),
        .BORDER_RGB (9'o700)
    ) dut (
        .vga_clk    (vga_clk),
        .vga_rst    (vga_rst),
        .rgb        (rgb),
        .pix_ptr_x  (pix_ptr_x),
        .pix_ptr_y  (pix_ptr_y),
        .fb_cs      (fb_cs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_de     (vga_de),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    always #20 vga_clk = ~vga_clk;

    // Framebuffer model with one clock of read latency
    always @(posedge vga_clk) begin
        rgb <= forceWhite ? 9'o777 : {pix_ptr_x[2:0], pix_ptr_y[2:0], 3'b101};
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
        edgeCount++;
        if (vga_rst) begin
            hModel = 0;
            vModel = 0;
        end else if (hModel == 799) begin
            hModel = 0;
            vModel = (vModel == V_LASTL) ? 0 : vModel + 1;
        end else begin
            hModel++;
        end
    endtask

    task automatic applyStimulus(input logic rst);
        vga_rst = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic waitState(input int h, input int v);
        int n = 0;
        while (!(hModel == h && vModel == v) && n < 30000) begin
            tick();
            n++;
        end
        if (n >= 30000) begin
            errors++;
            $error("[TB] FAIL waitState: observed timeout expected h=%0d v=%0d", h, v);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_hs"}, vga_hs, 1);
        checkOutput({tag, "_vs"}, vga_vs, 1);
        checkOutput({tag, "_de"}, vga_de, 0);
        checkOutput({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
        checkOutput({tag, "_vblank"}, vblank, 0);
        checkOutput({tag, "_ftick"}, frame_tick, 0);
    endtask

    task automatic checkColour(input string tag, input int r, input int g, input int b, input int de);
        checkOutput({tag, "_r"}, vga_r, r);
        checkOutput({tag, "_g"}, vga_g, g);
        checkOutput({tag, "_b"}, vga_b, b);
        checkOutput({tag, "_de"}, vga_de, de);
    endtask

    initial begin
        // Power-on reset held for three clocks
        applyStimulus(1'b1);
        repeat (3) tick();
        checkResetOutputs("rst");
        applyStimulus(1'b0);
        edgeCount = 0;

        // Addressing on line 0
        waitState(63, 0);
        checkOutput("ptr63_cs", fb_cs, 0);
        checkOutput("ptr63_x", pix_ptr_x, 0);
        waitState(64, 0);
        checkOutput("ptr64_cs", fb_cs, 1);
        checkOutput("ptr64_x", pix_ptr_x, 0);
        checkOutput("ptr64_y", pix_ptr_y, 0);
        waitState(66, 0);
        checkOutput("ptr66_x", pix_ptr_x, 1);
        waitState(576, 0);
        checkOutput("ptr576_cs", fb_cs, 0);
        checkOutput("ptr576_x", pix_ptr_x, 0);

        // Hsync: low 2 clocks after h=656, for 96 clocks
        waitState(656, 0);
        tick();
        checkOutput("hs_pre", vga_hs, 1);
        tick();
        checkOutput("hs_start", vga_hs, 0);
        runLen = 0;
        while (vga_hs == 1'b0 && runLen < 1000) begin
            runLen++;
            tick();
        end
        checkOutput("hs_width", runLen, 96);

        // DE high for the 640 visible pixels of line 1
        waitState(0, 1);
        tick();
        tick();
        checkOutput("de_start", vga_de, 1);
        runLen = 0;
        while (vga_de == 1'b1 && runLen < 1000) begin
            runLen++;
            tick();
        end
        checkOutput("de_width", runLen, 640);

        // Datapath on line 10
        waitState(10, 10);
        tick();
        tick();
        checkColour("border", 7, 0, 0, 1);
        waitState(100, 10);
        checkOutput("dp_ptr_x", pix_ptr_x, 18);
        checkOutput("dp_ptr_y", pix_ptr_y, 5);
        tick();
        tick();
        checkColour("pic", 2, 5, 5, 1);
        waitState(700, 10);
        tick();
        tick();
        checkColour("blank", 0, 0, 0, 0);

        // Last picture pixel of the last visible line
        waitState(575, V_ACT - 1);
        checkOutput("last_cs", fb_cs, 1);
        checkOutput("last_x", pix_ptr_x, 255);
        checkOutput("last_y", pix_ptr_y, 11);

        // First frame_tick 800*V_ACT+1 clocks after release
        waitState(0, V_ACT);
        tick();
        checkOutput("ftick_hi", frame_tick, 1);
        checkOutput("ftick_time", edgeCount, 800 * V_ACT + 1);
        checkOutput("vblank_hi", vblank, 1);
        tick();
        checkOutput("ftick_pulse", frame_tick, 0);

        // Vsync: low for two lines starting at v=28
        waitState(0, 28);
        tick();
        checkOutput("vs_pre", vga_vs, 1);
        tick();
        checkOutput("vs_start", vga_vs, 0);
        runLen = 0;
        while (vga_vs == 1'b0 && runLen < 5000) begin
            runLen++;
            tick();
        end
        checkOutput("vs_width", runLen, 1600);

        // Wrap: vblank drops one clock after returning to (0,0)
        waitState(799, V_LASTL);
        tick();
        checkOutput("wrap_vblank_hold", vblank, 1);
        tick();
        checkOutput("wrap_vblank_drop", vblank, 0);

        // Mid-frame reset
        waitState(123, 16);
        checkOutput("mid_de_before", vga_de, 1);
        applyStimulus(1'b1);
        tick();
        checkResetOutputs("midrst");
        checkOutput("midrst_cs", fb_cs, 0);
        applyStimulus(1'b0);
        tick();
        tick();
        checkOutput("restart_de", vga_de, 1);
        waitState(64, 0);
        checkOutput("restart_cs", fb_cs, 1);
        checkOutput("restart_y", pix_ptr_y, 0);

        forceWhite = 1'b1;
        waitState(100, 10);
        tick();
        tick();
        checkColour("white10", 7, 7, 7, 1);
        waitState(100, 20);
        tick();
        tick();
        checkColour("even20", 7, 7, 7, 1);
        waitState(10, 21);
        tick();
        tick();
        checkColour("border21", 7, 0, 0, 1);
        waitState(100, 21);
        tick();
        tick();
`ifdef SCANLINE_EN
        checkColour("odd21", 3, 3, 3, 1);
`else
        checkColour("odd21", 7, 7, 7, 1);
`endif
        waitState(700, 21);
        tick();
        tick();
        checkColour("blank21", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side master for the NES framebuffer. Generates 640x480@60 VGA timing from a 25 MHz pixel clock and drives the framebuffer's pixel read pointers (pix_ptr_x/pix_ptr_y).
- Takes the returned 9-bit rgb and outputs registered VGA colour and sync signals.
- Scales the 256x240 NES picture 2x2 to 512x480, centred horizontally, with a border colour on both sides.
- Provides vblank and frame_tick back to the PPU side.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (frame total 525)
- X_OFFSET, 64, first visible column of the NES picture
- FB_LAT, 1, framebuffer read latency in clocks (pointer to rgb valid), range 0..3
- BORDER_RGB, 9'o000, colour for visible pixels outside the picture

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- vga_rst  in  1  synchronous reset, active-high
- rgb  in  9  framebuffer read data: [8:6]=R, [5:3]=G, [2:0]=B
- pix_ptr_x  out  8  framebuffer column, 0..255
- pix_ptr_y  out  8  framebuffer row, 0..239
- fb_cs  out  1  framebuffer read enable; high only inside the picture
- vga_r, vga_g, vga_b  out  3 each  colour to DAC
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_de  out  1  visible-area flag, aligned with colour
- vblank  out  1  high while v >= V_ACTIVE
- frame_tick  out  1  1-cycle pulse at h=0, v=V_ACTIVE

Behaviour:
- Counters h (10b) and v (10b) are registered.
  - h: 0..799, increments every clock, wraps to 0.
  - v: increments when h wraps; wraps 524 -> 0 together with h.
- in_pic = (X_OFFSET <= h < X_OFFSET+512) && (v < V_ACTIVE).
- visible = (h < H_ACTIVE) && (v < V_ACTIVE).
- Pointers and fb_cs are combinational from the counters:
  - pix_ptr_x = (h - X_OFFSET) >> 1, pix_ptr_y = v >> 1 when in_pic.
  - Both are 0 when not in_pic.
  - fb_cs = in_pic.
- Stage 0 (counter cycle) computes:
  - hs_n = !(656 <= h < 752)
  - vs_n = !(490 <= v < 492)
  - de = visible
  - sel = in_pic
- Those stage-0 flags pass through an FB_LAT-deep shift register so they align with rgb.
- Output registers load on every clock:
  - colour = aligned sel ? rgb : (aligned de ? BORDER_RGB : 0)
  - vga_hs, vga_vs, vga_de = aligned values
- Total latency, counter value to pins: FB_LAT+1 clocks, identical for colour and sync.
- Colour is forced to 0 whenever aligned de = 0 (blanking), whatever rgb holds.
- vblank and frame_tick are registered from the counters with 1-clock latency and are not FB_LAT-delayed.
- Reset (any cycle, including mid-frame): next edge sets
  - h = v = 0
  - all delay stages cleared (hs/vs stages = 1, de/sel = 0)
  - vga_hs = vga_vs = 1, vga_de = 0, colour = 0
  - vblank = 0, frame_tick = 0
- After reset release, counting resumes from h=0, v=0 on the first non-reset edge. There is no partial-frame recovery.
- Wrap: at h=799, v=524 the next state is h=0, v=0; vblank drops 1 clock later.
- rgb is ignored (not sampled into colour) while not in_pic.

Optional Feature:
- Macro: SCANLINE_EN.
- Defined: on odd VGA lines (v[0]=1) inside the picture, each 3-bit channel is shifted right by 1 before the output register (e.g. R=7 -> 3). Border and blanking are unaffected. Latency is unchanged.
- Undefined: no dimming; colour passes through unmodified.

Test Plan:
- Reset: assert vga_rst 3 clocks at an arbitrary point -> vga_hs=vga_vs=1, vga_de=0, RGB=0, vblank=0; the first frame_tick comes 384001 clocks after release (800*480+1).
- Hsync: FB_LAT=1 -> vga_hs low for exactly 96 clocks starting 2 clocks after h=656; period 800 clocks; vga_de high 640 clocks per visible line.
- Vsync: vga_vs low for exactly 1600 clocks starting at v=490; frame period 420000 clocks; vblank high for 45 lines.
- Addressing: h=64,v=0 -> (0,0), fb_cs=1; h=66 -> x=1; h=575,v=479 -> (255,239); h=63 or h=576 -> fb_cs=0, pointers 0.
- Datapath: fb model rgb = {x[2:0], y[2:0], 3'b101} with FB_LAT=1, BORDER_RGB=9'o700; at v=10, h=100 (pointer (18,5)) -> 2 clocks later R=2, G=5, B=5, de=1; at h=10 -> R=7, G=0, B=0; at h=700 -> colour 0, de=0.
- Mid-frame reset at v=300, then repeat the Datapath check with SCANLINE_EN defined -> outputs reset on the next edge and counting restarts at h=0, v=0; afterwards on line v=21 a pixel with rgb 9'o777 -> R=G=B=3, and on v=20 -> 7.
